mmio_uart_rx: RTL
=================

Name: mmio_uart_rx

Overview:
- Memory-mapped UART receiver: the input-direction counterpart of the store-only display register at 16'hFFFF.
- Deserialises 8N1 frames from a pin and buffers bytes in a small FIFO.
- Exposes a data register and a status register to the core's data bus with the same one-cycle read latency as the data memory.
- Top level ORs/muxes o_rd_data into i_mem_rd_data using o_sel.

Parameters:
- p_CLKS_PER_BIT, 16, clock cycles per serial bit (>=4, even)
- p_FIFO_ADDR_LEN, 3, log2 FIFO depth (depth 8)
- p_DATA_ADDR, 16'hFFFE, address of RX data register
- p_STAT_ADDR, 16'hFFFD, address of status/control register

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_rx  in  1  serial input, idle high, asynchronous to i_clk
- i_mem_addr  in  16  core data address (o_mem_addr)
- i_mem_wr_en  in  1  core store strobe
- i_mem_wr_data  in  16  core store data
- o_rd_data  out  16  registered read data
- o_sel  out  1  registered: previous-cycle address hit this block
- o_rx_avail  out  1  FIFO not empty (level)

Behaviour:
- Reset (async, immediate): o_rd_data=0, o_sel=0, o_rx_avail=0, FIFO empty, flags cleared, FSM IDLE, sync flops=1, counters 0.
- Input: 2-flop synchroniser plus one delay flop for falling-edge detect.
- FSM:
  - IDLE: on synced falling edge -> START with bit counter = p_CLKS_PER_BIT/2-1.
  - START: at count 0, sample line. If 0 -> DATA (bit idx 0, counter reload p_CLKS_PER_BIT-1). If 1 -> IDLE (glitch rejected).
  - DATA: sample at each count 0, LSB first into shift reg; after bit 7 -> STOP.
  - STOP: sample at count 0. If 1 -> push byte. If 0 -> set FRM flag, drop byte. Always -> IDLE.
  - Line held low after a framing error produces no new frame until a new falling edge.
- Push: if FIFO full and no pop this cycle -> byte dropped, OVR flag set. Push and pop in the same cycle are both performed, even when full; count unchanged, no overrun.
- Reads: on every edge, o_sel <= (addr==DATA || addr==STAT), and o_rd_data is loaded from pre-edge state:
  - DATA: {8'h00, head byte} if not empty, else 16'h0000.
  - STAT: [0]=not empty, [1]=full, [2]=OVR, [3]=FRM, [7:4]=0, [15:8]=FIFO count (zero-extended).
  - Other addresses: 16'h0000.
- Writes (i_mem_wr_en):
  - To DATA: pop head if not empty; ignored if empty; data value ignored.
  - To STAT: wr_data[2]=1 clears OVR, wr_data[3]=1 clears FRM; other bits ignored.
  - A flag set and a clear in the same cycle: set wins.
- Read data is never side-effecting. A read of DATA returns the same byte until an explicit pop store.
- FIFO pointers wrap modulo depth. Count is p_FIFO_ADDR_LEN+1 bits.
- Latency: byte is visible in STAT[0] on the cycle after the STOP sample edge. Worst case from start-bit falling edge at pin: 3 + 9.5*p_CLKS_PER_BIT cycles.

Decomposition:
- Shared include mmio_defs.vh holds: address constants (display 16'hFFFF, RX data, RX status) and status bit positions (AVAIL=0, FULL=1, OVR=2, FRM=3, COUNT_LSB=8).
- One sub-module, sync_fifo: parameterised width/addr-len; push/pop/full/empty/count; head visible combinationally. Reusable for a future TX block.
- FSM, synchroniser and register decode stay in mmio_uart_rx.

Test Plan:
- Reset, read STAT: one cycle later o_sel=1, o_rd_data=16'h0000. Read 16'h0010: o_sel=0, o_rd_data=0.
- Send 0xA5 at 16 clk/bit: STAT reads 16'h0101, DATA reads 16'h00A5 twice. Store to DATA: STAT reads 16'h0000, o_rx_avail=0.
- Send 9 bytes 0x01..0x09 without popping: STAT=16'h0807 (count 8, full, OVR). Eight pop/read cycles return 0x01..0x08. Store 16'h0004 to STAT clears OVR.
- Frame 0x3C with stop bit 0: STAT=16'h0008, FIFO empty. Store 16'h0008 to STAT -> STAT=16'h0000.
- Low pulse of 4 clk (< half bit): no byte, FSM back in IDLE. Following valid 0x5A is received correctly.
- Assert i_rst during data bit 4: outputs 0 immediately without a clock edge. Subsequent 0xC3 frame is received, DATA=16'h00C3.

Source files
------------

// File: rtl/mmio_uart_rx_pkg.sv
// Shared definitions for the memory-mapped UART receiver.
// Bus addresses, status bit positions and receiver FSM states.
package mmio_uart_rx_pkg;

  localparam logic [15:0] DISP_ADDR    = 16'hFFFF;
  localparam logic [15:0] RX_DATA_ADDR = 16'hFFFE;
  localparam logic [15:0] RX_STAT_ADDR = 16'hFFFD;

  localparam int STAT_AVAIL     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVR       = 2;
  localparam int STAT_FRM       = 3;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head and occupancy count.
// Push while full succeeds only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int p_WIDTH    = 8,
  parameter int p_ADDR_LEN = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [p_WIDTH-1:0]    i_data,
  input  logic                  i_pop,
  output logic [p_WIDTH-1:0]    o_head,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [p_ADDR_LEN:0]   o_count
);

  localparam int DEPTH = 1 << p_ADDR_LEN;

  logic [p_WIDTH-1:0]    mem [DEPTH];
  logic [p_ADDR_LEN-1:0] wr_ptr;
  logic [p_ADDR_LEN-1:0] rd_ptr;
  logic [p_ADDR_LEN:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign o_empty = (count == '0);
  assign o_full  = (count == (p_ADDR_LEN+1)'(DEPTH));
  assign o_count = count;
  assign o_head  = mem[rd_ptr];

  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  // Storage array; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_data;
  end

  // Pointers wrap naturally; count tracks net push/pop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_rx.sv
// Memory-mapped 8N1 UART receiver with byte FIFO.
// Data/status registers read back with one cycle of latency.
module mmio_uart_rx
  import mmio_uart_rx_pkg::*;
#(
  parameter int          p_CLKS_PER_BIT  = 16,
  parameter int          p_FIFO_ADDR_LEN = 3,
  parameter logic [15:0] p_DATA_ADDR     = RX_DATA_ADDR,
  parameter logic [15:0] p_STAT_ADDR     = RX_STAT_ADDR
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx,
  input  logic [15:0] i_mem_addr,
  input  logic        i_mem_wr_en,
  input  logic [15:0] i_mem_wr_data,
  output logic [15:0] o_rd_data,
  output logic        o_sel,
  output logic        o_rx_avail
);

  localparam int CW = $clog2(p_CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_BIT = CW'(p_CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(p_CLKS_PER_BIT / 2 - 1);

  logic rx_s1, rx_s2, rx_d;
  logic fall;

  rx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic          push, frm_set;

  logic [7:0]               head;
  logic                     full, empty;
  logic [p_FIFO_ADDR_LEN:0] count;

  logic hit_data, hit_stat;
  logic pop, ovr_set;
  logic ovr, frm;
  logic [15:0] stat, rd_mux;
  logic unused_wr_bits;

  assign unused_wr_bits = ^{i_mem_wr_data[15:4], i_mem_wr_data[1:0]};

  // Two-flop synchroniser plus delay flop for edge detect.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= i_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign fall = rx_d & ~rx_s2;

  // Receiver FSM state and datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
    end
  end

  // Next-state: mid-bit sampling driven by a down-counter.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    push    = 1'b0;
    frm_set = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (fall) begin
          state_n = ST_START;
          cnt_n   = HALF_BIT;
        end
      end
      ST_START: begin
        if (cnt == '0) begin
          if (!rx_s2) begin
            state_n = ST_DATA;
            idx_n   = '0;
            cnt_n   = FULL_BIT;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt == '0) begin
          sh_n  = {rx_s2, sh[7:1]};
          cnt_n = FULL_BIT;
          if (idx == 3'd7) state_n = ST_STOP;
          else             idx_n   = idx + 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt == '0) begin
          state_n = ST_IDLE;
          if (rx_s2) push    = 1'b1;
          else       frm_set = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign hit_data = (i_mem_addr == p_DATA_ADDR);
  assign hit_stat = (i_mem_addr == p_STAT_ADDR);
  assign pop      = i_mem_wr_en & hit_data;
  assign ovr_set  = push & full & ~(pop & ~empty);

  sync_fifo #(
    .p_WIDTH    (8),
    .p_ADDR_LEN (p_FIFO_ADDR_LEN)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_data  (sh),
    .i_pop   (pop),
    .o_head  (head),
    .o_full  (full),
    .o_empty (empty),
    .o_count (count)
  );

  // Sticky error flags; a set beats a same-cycle clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ovr <= 1'b0;
      frm <= 1'b0;
    end else begin
      if (ovr_set)
        ovr <= 1'b1;
      else if (i_mem_wr_en & hit_stat & i_mem_wr_data[STAT_OVR])
        ovr <= 1'b0;
      if (frm_set)
        frm <= 1'b1;
      else if (i_mem_wr_en & hit_stat & i_mem_wr_data[STAT_FRM])
        frm <= 1'b0;
    end
  end

  // Status word assembly.
  always_comb begin
    stat = '0;
    stat[STAT_AVAIL] = ~empty;
    stat[STAT_FULL]  = full;
    stat[STAT_OVR]   = ovr;
    stat[STAT_FRM]   = frm;
    stat[STAT_COUNT_LSB +: p_FIFO_ADDR_LEN+1] = count;
  end

  // Read mux from pre-edge state.
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      hit_data: rd_mux = empty ? 16'h0000 : {8'h00, head};
      hit_stat: rd_mux = stat;
      default:  rd_mux = '0;
    endcase
  end

  // Registered bus read port.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sel     <= 1'b0;
      o_rd_data <= '0;
    end else begin
      o_sel     <= hit_data | hit_stat;
      o_rd_data <= rd_mux;
    end
  end

  assign o_rx_avail = ~empty;

endmodule
